spi_reg_bank: RTL



---
 rtl/spi_reg_bank_pkg.sv | 21 ++
 rtl/spi_reg_bank_rx_edge.sv | 21 ++
 rtl/spi_reg_bank.sv | 123 ++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: FSM states, fixed addresses
// and the burst address step.
package spi_reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RD   = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  localparam logic [6:0] ADDR_VERSION = 7'd0;
  localparam int         CMD_WR_BIT   = 7;
  localparam logic [6:0] RW_BASE      = 7'd1;

  // The 7-bit address space wraps 0x7F -> 0x00 when incrementing.
  function automatic logic [6:0] next_addr(input logic [6:0] a, input bit auto_inc);
    return auto_inc ? a + 7'd1 : a;
  endfunction

endpackage

// File: rtl/spi_reg_bank_rx_edge.sv
// Rising-edge detector on the spi_slave byte-available level; byte_evt is
// combinational from the registered history so the byte is handled that cycle.
module spi_rx_edge
  import spi_reg_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx_byte_available,
  output logic byte_evt
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= rx_byte_available;
  end

  assign byte_evt = rx_byte_available & ~prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI register file behind spi_slave: version byte, NUM_RW control registers
// and NUM_RO status inputs with burst read/write and optional auto-increment.
//
// state   | meaning
// IDLE    | no transaction open, byte events ignored
// CMD     | next byte is the command (bit7 write, 6:0 start address)
// RD      | read burst, tx_byte carries the next address' value
// WR      | write burst, each byte goes to the current address
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter logic [7:0]          FPGA_VER = 8'hC2,
  parameter int                  NUM_RW   = 4,
  parameter int                  NUM_RO   = 4,
  parameter logic [8*NUM_RW-1:0] RW_RESET = {NUM_RW{8'h00}},
  parameter bit                  AUTO_INC = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                transaction_begin,
  input  logic                rx_byte_available,
  input  logic [7:0]          rx_byte,
  output logic [7:0]          tx_byte,
  input  logic [8*NUM_RO-1:0] ro_data,
  output logic [8*NUM_RW-1:0] rw_data,
  output logic [NUM_RW-1:0]   wr_strobe
);

  if (NUM_RW < 1 || NUM_RW > 32 || NUM_RO < 1 || NUM_RO > 32 ||
      NUM_RW + NUM_RO > 127) begin : g_bad_cfg
    $error("spi_reg_bank: NUM_RW/NUM_RO out of range or map exceeds 127 addresses");
  end

  state_t      state;
  logic [6:0]  addr;
  logic        byte_evt;
  logic [7:0]  rw_q [NUM_RW];
  logic [NUM_RW-1:0] wr_hit;
  logic [NUM_RW-1:0] wr_en;
  logic [6:0]  cmd_addr;
  logic [6:0]  nxt_addr;
  logic [7:0]  rd_cmd;
  logic [7:0]  rd_nxt;

  spi_rx_edge u_rx_edge (
    .clk               (clk),
    .reset             (reset),
    .rx_byte_available (rx_byte_available),
    .byte_evt          (byte_evt)
  );

  // Shifts rather than indexed selects keep the mux width-exact for any map size.
  function automatic logic [7:0] rdmux(input logic [6:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == ADDR_VERSION)
      v = FPGA_VER;
    else if (a >= RW_BASE && a <= 7'(NUM_RW))
      v = 8'(rw_data >> {a - RW_BASE, 3'b000});
    else if (a > 7'(NUM_RW) && a <= 7'(NUM_RW + NUM_RO))
      v = 8'(ro_data >> {a - 7'(NUM_RW + 1), 3'b000});
    return v;
  endfunction

  always_comb begin
    cmd_addr = rx_byte[6:0];
    nxt_addr = next_addr(addr, AUTO_INC);
    rd_cmd   = rdmux(cmd_addr);
    rd_nxt   = rdmux(nxt_addr);
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
    assign wr_hit[g] = (addr == 7'(g + 1));
    assign rw_data[8*g +: 8] = rw_q[g];

    always_ff @(posedge clk) begin
      if (reset)       rw_q[g] <= RW_RESET[8*g +: 8];
      else if (wr_en[g]) rw_q[g] <= rx_byte;
    end
  end

  // transaction_begin outranks a coincident byte, so that byte never writes.
  assign wr_en = (state == ST_WR && byte_evt && !transaction_begin) ? wr_hit : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      addr      <= 7'd0;
      tx_byte   <= 8'h00;
      wr_strobe <= '0;
    end else begin
      wr_strobe <= wr_en;
      if (transaction_begin) begin
        state   <= ST_CMD;
        tx_byte <= 8'h00;
      end else if (byte_evt) begin
        unique case (state)
          ST_IDLE: ;
          ST_CMD: begin
            addr <= cmd_addr;
            if (rx_byte[CMD_WR_BIT]) begin
              state   <= ST_WR;
              tx_byte <= 8'h00;
            end else begin
              state   <= ST_RD;
              tx_byte <= rd_cmd;
            end
          end
          ST_RD: begin
            addr    <= nxt_addr;
            tx_byte <= rd_nxt;
          end
          ST_WR: begin
            addr    <= nxt_addr;
            tx_byte <= 8'h00;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
